seg_display_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment driver for the DDR game board, replacing the fixed 4-digit display logic. Accepts a binary value (score or combo count) and converts it to decimal with a sequential double-dabble engine. Alternatively accepts raw per-digit glyphs for the arrow patterns shown during gameplay. Scans the digits at a programmable refresh rate, with optional leading-zero blanking and blinking, and sits between the game FSM and the board's `seg`/`an` pins.

---
 rtl/seg_display_mux_if.sv | 29 ++
 rtl/seg_display_mux.sv | 213 +++++++++++++++++++++
 tb/tb_seg_display_mux.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_mux_if.sv
// Handshake and pin bundle between the game FSM and the
// seven-segment display multiplexer.
interface seg_display_mux_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_WIDTH = 14
);
  logic [VALUE_WIDTH-1:0]  value;
  logic                    value_load;
  logic [1:0]              mode;
  logic [7*NUM_DIGITS-1:0] glyphs;
  logic                    blank_lz;
  logic                    blink_en;
  logic                    busy;
  logic                    overflow;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output value, value_load, mode, glyphs,
    output blank_lz, blink_en,
    input  busy, overflow, seg, an
  );

  modport slave (
    input  value, value_load, mode, glyphs,
    input  blank_lz, blink_en,
    output busy, overflow, seg, an
  );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with a sequential
// double-dabble converter, glyph mode, blanking and blink.
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_WIDTH = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic clk,
  input  logic rst,
  seg_display_mux_if.slave bus
);

  localparam int BW  = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(VALUE_WIDTH + 1);
  localparam int RW  = $clog2(REFRESH_DIV);
  localparam int KW  = $clog2(BLINK_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] LIMIT = pow10(NUM_DIGITS);
  localparam logic [BW-1:0] NINES = {NUM_DIGITS{4'd9}};

  function automatic logic [6:0] dec7(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]          bcd_q, bcd_d, adj;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovp_q, ovp_d;
  logic [BW-1:0]          dig_q, dig_d;
  logic                   ovf_q, ovf_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovp_d   = ovp_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.value_load) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          cnt_d   = CW'(VALUE_WIDTH);
          ovp_d   = {{(32-VALUE_WIDTH){1'b0}}, bus.value} >= LIMIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        dig_d   = ovp_q ? NINES : bcd_q;
        ovf_d   = ovp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovp_q   <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovp_q   <= ovp_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

  logic [RW-1:0] ref_q;
  logic [IW-1:0] idx_q;
  logic [KW-1:0] blk_q;
  logic          off_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      blk_q <= '0;
      off_q <= 1'b0;
    end else begin
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ?
                 '0 : idx_q + IW'(1);
      end else begin
        ref_q <= ref_q + RW'(1);
      end
      if (blk_q == KW'(BLINK_DIV - 1)) begin
        blk_q <= '0;
        off_q <= ~off_q;
      end else begin
        blk_q <= blk_q + KW'(1);
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_above;
  logic [3:0]            cur_dig;
  logic [6:0]            cur_gly;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;

  // Digit k is blank only if it and every higher digit are zero.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (dig_q[4*k +: 4] == 4'd0);
      lz[k]      = zero_above;
    end
  end

  always_comb begin
    cur_dig = '0;
    cur_gly = '1;
    cur_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig = dig_q[4*k +: 4];
        cur_gly = bus.glyphs[7*k +: 7];
        cur_lz  = lz[k];
      end
    end
    an_sel = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
    unique case (1'b1)
      bus.mode == 2'd0: begin
        seg_d = (bus.blank_lz && cur_lz) ? 7'h7F : dec7(cur_dig);
        an_d  = an_sel;
      end
      bus.mode == 2'd1: begin
        seg_d = cur_gly;
        an_d  = an_sel;
      end
      default: ;
    endcase
    if (bus.blink_en && off_q) an_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized self-checking bench for seg_display_mux against
// a decimal-arithmetic display model.
module tb_seg_display_mux;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_display_mux_if #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW)) bus();

  seg_display_mux #(
    .NUM_DIGITS(ND), .VALUE_WIDTH(VW),
    .REFRESH_DIV(RD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000
  };

  int             m_value = 0;
  logic           m_blz   = 1'b0;
  int             m_mode  = 0;
  logic [7*ND-1:0] m_glyph = '1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int k);
    if (m_mode == 1) return m_glyph[7*k +: 7];
    if (m_value >= p10(ND)) return SEG[9];
    if (m_blz && k > 0 && m_value < p10(k)) return 7'h7F;
    return SEG[(m_value / p10(k)) % 10];
  endfunction

  task automatic apply_ctrl();
    bus.mode     = 2'(m_mode);
    bus.blank_lz = m_blz;
    bus.glyphs   = m_glyph;
    @(negedge clk);
  endtask

  task automatic convert(input int v, input int late_v);
    int n;
    bus.value      = VW'(v);
    bus.value_load = 1'b1;
    @(negedge clk);
    bus.value_load = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 3 && late_v >= 0) begin
        bus.value      = VW'(late_v);
        bus.value_load = 1'b1;
      end else begin
        bus.value_load = 1'b0;
      end
      @(negedge clk);
    end
    bus.value_load = 1'b0;
    check("busy_len", n, VW + 1);
    m_value = v;
    @(negedge clk);
    check("overflow", 32'(bus.overflow), 32'(m_value >= p10(ND)));
  endtask

  task automatic check_frame();
    int seen [ND];
    int prev;
    int k;
    foreach (seen[i]) seen[i] = 0;
    prev = -1;
    for (int c = 0; c < ND * RD; c++) begin
      @(negedge clk);
      if (m_mode >= 2) begin
        check("blank_an", 32'(bus.an), 32'((1 << ND) - 1));
        check("blank_seg", 32'(bus.seg), 32'h7F);
      end else begin
        k = -1;
        for (int i = 0; i < ND; i++)
          if (bus.an == ~(ND'(1) << i)) k = i;
        check("an_onehot", 32'(k >= 0), 32'd1);
        if (k >= 0) begin
          seen[k]++;
          if (prev >= 0 && k != prev)
            check("scan_order", k, (prev + 1) % ND);
          prev = k;
          check($sformatf("seg_slot%0d", k),
                32'(bus.seg), 32'(model_seg(k)));
        end
      end
    end
    if (m_mode < 2)
      for (int i = 0; i < ND; i++) check("dwell", seen[i], RD);
  endtask

  task automatic check_reset_outs();
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_an", 32'(bus.an), 32'((1 << ND) - 1));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises [$];
    int prevb, g, pg, run, runs, lit_gated;

    bus.value      = '0;
    bus.value_load = 1'b0;
    bus.mode       = 2'd0;
    bus.glyphs     = '1;
    bus.blank_lz   = 1'b0;
    bus.blink_en   = 1'b0;

    #1 rst = 1'b1;
    #1 check_reset_outs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    m_value = 0;
    check_frame();

    convert(1234, -1);
    check_frame();

    m_blz = 1'b1; apply_ctrl();
    convert(7, -1);
    check_frame();
    convert(0, -1);
    check_frame();

    m_blz = 1'b0; apply_ctrl();
    convert(1234, 42);
    check_frame();

    convert(12000, -1);
    check_frame();
    convert(5, -1);
    check_frame();
    convert(9999, -1);
    check_frame();
    convert(10000, -1);
    check_frame();

    for (int i = 0; i < 12; i++) begin
      m_blz = 1'($urandom_range(0, 1));
      apply_ctrl();
      convert(int'($urandom_range(0, (1 << VW) - 1)), -1);
      check_frame();
    end

    m_mode  = 1;
    m_glyph = {7'h7E, 7'h3F, 7'h00, 7'h55};
    apply_ctrl();
    check_frame();
    for (int i = 0; i < 3; i++) begin
      m_glyph = (7*ND)'($urandom);
      apply_ctrl();
      check_frame();
    end
    m_mode = 2; apply_ctrl(); check_frame();
    m_mode = 3; apply_ctrl(); check_frame();
    m_mode = 0; m_blz = 1'b0; apply_ctrl();

    bus.value      = VW'(100);
    bus.value_load = 1'b1;
    prevb = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.busy && prevb == 0) rises.push_back(c);
      prevb = int'(bus.busy);
    end
    bus.value_load = 1'b0;
    check("hold_rises", 32'(rises.size() >= 3), 32'd1);
    for (int i = 1; i < rises.size(); i++)
      check("hold_period", rises[i] - rises[i-1], VW + 2);
    for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
    @(negedge clk);
    m_value = 100;
    check_frame();

    bus.blink_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pg = int'(bus.an == '1);
    run = 1;
    runs = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      g = int'(bus.an == '1);
      if (g != pg) begin
        if (runs > 0) check("blink_run", run, BD);
        runs++;
        run = 1;
        pg = g;
      end else begin
        run++;
      end
    end
    check("blink_runs", 32'(runs >= 6), 32'd1);

    bus.blink_en = 1'b0;
    @(negedge clk);
    lit_gated = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.an == '1) lit_gated++;
    end
    check("no_blink", lit_gated, 0);

    convert(12000, -1);
    bus.value      = VW'(321);
    bus.value_load = 1'b1;
    @(negedge clk);
    bus.value_load = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outs();
    @(negedge clk);
    rst = 1'b0;
    repeat (VW + 4) @(negedge clk);
    check("busy_after_rst", 32'(bus.busy), 32'd0);
    check("ovf_after_rst", 32'(bus.overflow), 32'd0);
    m_value = 0;
    check_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
